// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, default latencies.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MFHI  = 4'd7,
      OP_MFLO  = 4'd8
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/mdu.sv
// MIPS-style HI/LO multiply/divide unit with fixed-latency MULT/DIV and single-cycle MTHI/MTLO.
// Latency: HI/LO update LAT edges after an accepted MULT*/DIV*; MTHI/MTLO at the accepting edge; rd_data combinational.
// Backpressure: busy is high for exactly LAT cycles; any start seen while busy is dropped.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd_data
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   op_e                op_q;
   logic [31:0]        a_q, b_q;
   logic [31:0]        hi_q, lo_q;

   op_e                op_in;
   logic               idle, is_muldiv, accept, done;
   logic               signed_div, upd;
   logic [63:0]        prod_s, prod_u;
   logic [31:0]        mag_a, mag_b, div_b, q_mag, r_mag;
   logic [31:0]        res_hi, res_lo;

   assign op_in     = op_e'(op);
   assign idle      = (state_q == ST_IDLE);
   assign is_muldiv = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                      (op_in == OP_DIV)  || (op_in == OP_DIVU);
   assign accept    = start && idle && is_muldiv;
   assign done      = (state_q == ST_RUN) && (cnt_q == '0);

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: leave IDLE on an accepted mul/div, return when the countdown hits zero
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == '0) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Latch operands/op on accept and count down the remaining RUN cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         op_q  <= OP_NONE;
         a_q   <= '0;
         b_q   <= '0;
      end else if (accept) begin
         op_q  <= op_in;
         a_q   <= rs_data;
         b_q   <= rt_data;
         if ((op_in == OP_MULT) || (op_in == OP_MULTU)) cnt_q <= CNT_W'(MULT_LAT - 1);
         else                                           cnt_q <= CNT_W'(DIV_LAT - 1);
      end else if ((state_q == ST_RUN) && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // Result datapath from latched operands; signed divide is done on magnitudes so that
   // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0
   always_comb begin
      signed_div = (op_q == OP_DIV);
      prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      prod_u = {32'd0, a_q} * {32'd0, b_q};
      mag_a  = (signed_div && a_q[31]) ? (32'd0 - a_q) : a_q;
      mag_b  = (signed_div && b_q[31]) ? (32'd0 - b_q) : b_q;
      div_b  = (b_q == 32'd0) ? 32'd1 : mag_b;
      q_mag  = mag_a / div_b;
      r_mag  = mag_a % div_b;
      res_hi = '0;
      res_lo = '0;
      upd    = 1'b0;
      case (op_q)
         OP_MULT: begin
            {res_hi, res_lo} = prod_s;
            upd = 1'b1;
         end
         OP_MULTU: begin
            {res_hi, res_lo} = prod_u;
            upd = 1'b1;
         end
         OP_DIV, OP_DIVU: begin
            res_lo = (signed_div && (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
            res_hi = (signed_div && a_q[31]) ? (32'd0 - r_mag) : r_mag;
            upd    = (b_q != 32'd0);
         end
         default: upd = 1'b0;
      endcase
   end

   // HI/LO: registered result at completion, or direct move-to when idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (done && upd) begin
         hi_q <= res_hi;
         lo_q <= res_lo;
      end else if (start && idle && (op_in == OP_MTHI)) begin
         hi_q <= rs_data;
      end else if (start && idle && (op_in == OP_MTLO)) begin
         lo_q <= rs_data;
      end
   end

   // Move-from read port
   always_comb begin
      rd_data = '0;
      if (op_in == OP_MFHI)      rd_data = hi_q;
      else if (op_in == OP_MFLO) rd_data = lo_q;
   end

   assign busy = (state_q == ST_RUN);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: mul/div results, latency, ignored starts, reset abort.
// Latency: checks busy width equals MULT_LAT/DIV_LAT defaults.
// Backpressure: exercises starts issued while busy.
module tb_mdu;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rd_data;

   int passed = 0;
   int total  = 0;

   mdu dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .rd_data (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Issue one mul/div, check busy width, old HI/LO during RUN and the final HI/LO
   task automatic run_op(input string tag, input op_e o, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] oh, input logic [31:0] ol,
                         input logic [31:0] eh, input logic [31:0] el);
      int n;
      @(negedge clk);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      @(posedge clk); #1;
      start = 1'b0; op = OP_NONE;
      chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == lat - 1) begin
            chk({tag, " hi_old_in_run"}, hi, oh);
            chk({tag, " lo_old_in_run"}, lo, ol);
         end
      end while (busy && n < 64);
      chk({tag, " busy_cycles"}, 32'(n), 32'(lat));
      chk({tag, " hi"}, hi, eh);
      chk({tag, " lo"}, lo, el);
   endtask

   initial begin
      int n;
      reset = 1'b0; start = 1'b0; op = OP_NONE; rs_data = '0; rt_data = '0;
      #1;
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset rd_data", rd_data, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // 3 * -2 = -6
      run_op("mult", OP_MULT, 32'd3, 32'hFFFF_FFFE, 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      // -7 / 2 = -3 rem -1
      run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
             32'hFFFF_FFFF, 32'hFFFF_FFFD);
      // 7 / -2 = -3 rem 1
      run_op("div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
             32'd1, 32'hFFFF_FFFD);
      run_op("divu", OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'hFFFF_FFFD, 32'd1, 32'd3);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd1, 32'd3,
             32'd0, 32'h8000_0000);

      // MTHI takes effect at the same edge, no busy
      @(negedge clk);
      start = 1'b1; op = OP_MTHI; rs_data = 32'h1234;
      @(posedge clk); #1;
      start = 1'b0; op = OP_NONE;
      chk("mthi hi", hi, 32'h1234);
      chk("mthi lo", lo, 32'h8000_0000);
      chk("mthi busy", 32'(busy), 32'd0);

      // divide by zero: full latency, HI/LO untouched
      run_op("div0", OP_DIV, 32'd5, 32'd0, 10, 32'h1234, 32'h8000_0000, 32'h1234, 32'h8000_0000);

      // MULT 5*7, then MTLO and DIVU issued while busy must be dropped
      @(negedge clk);
      start = 1'b1; op = OP_MULT; rs_data = 32'd5; rt_data = 32'd7;
      @(posedge clk); #1;
      op = OP_MTLO; rs_data = 32'h55;
      @(posedge clk); #1;
      chk("ignore mtlo lo", lo, 32'h8000_0000);
      chk("ignore busy", 32'(busy), 32'd1);
      op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; op = OP_NONE;
      n = 2;
      while (busy && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ignore busy_cycles", 32'(n), 32'd5);
      chk("ignore hi", hi, 32'd0);
      chk("ignore lo", lo, 32'h23);

      run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'd0, 32'h23,
             32'hFFFF_FFFE, 32'd1);

      // move-from read port and no-op starts
      @(negedge clk);
      start = 1'b1; op = OP_MFHI;
      #1 chk("mfhi rd_data", rd_data, 32'hFFFF_FFFE);
      op = OP_MFLO;
      #1 chk("mflo rd_data", rd_data, 32'd1);
      op = OP_NONE;
      #1 chk("none rd_data", rd_data, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("none busy", 32'(busy), 32'd0);
      chk("none hi", hi, 32'hFFFF_FFFE);
      chk("none lo", lo, 32'd1);

      // reset mid-RUN aborts the operation
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      start = 1'b0; op = OP_NONE;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_mid hi", hi, 32'd0);
      chk("rst_mid lo", lo, 32'd0);
      chk("rst_mid busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("rst_after hi", hi, 32'd0);
      chk("rst_after lo", lo, 32'd0);
      chk("rst_after busy", 32'(busy), 32'd0);

      run_op("mult_post_rst", OP_MULT, 32'd2, 32'd3, 5, 32'd0, 32'd0, 32'd0, 32'd6);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
